// File: rtl/uart_baud_pkg.sv
// Shared defaults and types for the UART baud tick generator.
package uart_baud_pkg;

  localparam int unsigned WORD_DEF = 16;
  localparam int unsigned FRAC_DEF = 4;
  localparam int unsigned OVS_DEF  = 16;

  typedef logic [WORD_DEF-1:0] div_int_t;
  typedef logic [FRAC_DEF-1:0] div_frac_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

endpackage

// File: rtl/frac_div.sv
// Fractional period counter: down-counter with a phase accumulator whose
// carry stretches a period by one cycle. zero_o flags the tick cycle.
module frac_div
  import uart_baud_pkg::*;
#(
  parameter int unsigned WORD = WORD_DEF,
  parameter int unsigned FRAC = FRAC_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            restart_i,
  input  logic [WORD-1:0] div_int_i,
  input  logic [FRAC-1:0] div_frac_i,
  output logic            zero_o
);

  run_state_e      state;
  logic [WORD-1:0] cnt;
  logic [FRAC-1:0] acc;
  logic [FRAC:0]   acc_sum;
  logic [WORD-1:0] reload;

  assign zero_o = (state == ST_RUN) && (cnt == '0);

  // Next accumulator value and reload length (period-1, plus one on carry).
  always_comb begin
    acc_sum = {1'b0, acc} + {1'b0, div_frac_i};
    reload  = div_int_i - WORD'(1) + WORD'(acc_sum[FRAC]);
  end

  // Period counter and accumulator; restart aligns timing without a tick.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      acc   <= '0;
    end else if (clr_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      acc   <= '0;
    end else if (restart_i) begin
      state <= ST_RUN;
      cnt   <= div_int_i - WORD'(1);
      acc   <= '0;
    end else if (state == ST_IDLE) begin
      state <= ST_RUN;
      cnt   <= div_int_i - WORD'(1);
    end else if (cnt == '0) begin
      cnt <= reload;
      acc <= acc_sum[FRAC-1:0];
    end else begin
      cnt <= cnt - WORD'(1);
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator: oversample/mid-bit/bit-boundary pulses from a
// fractional divisor, with shadowed divisor updates at bit boundaries.
module baud_tick_gen
  import uart_baud_pkg::*;
#(
  parameter int unsigned WORD = WORD_DEF,
  parameter int unsigned FRAC = FRAC_DEF,
  parameter int unsigned OVS  = OVS_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [WORD-1:0] div_int_i,
  input  logic [FRAC-1:0] div_frac_i,
  input  logic            div_wr_i,
  input  logic            resync_i,
  output logic            os_tick_o,
  output logic            half_tick_o,
  output logic            bit_tick_o,
  output logic            baud_clk_o,
  output logic            active_o
);

  localparam int unsigned CW = $clog2(OVS);

  logic [WORD-1:0] shadow_int, act_int, int_nxt;
  logic [FRAC-1:0] shadow_frac, act_frac, frac_nxt;
  logic            pending;
  logic            zero, bit_raw, apply, clr, restart, tick_ev;
  logic            half_ev, bit_ev;
  logic [CW-1:0]   os_cnt;

  // Divisor that will be active after this edge. The bit-boundary test uses
  // the raw counter state so the divisor choice never feeds back into it.
  always_comb begin
    bit_raw  = zero && (os_cnt == CW'(OVS - 1));
    apply    = pending && (resync_i || bit_raw || (act_int == '0));
    int_nxt  = act_int;
    frac_nxt = act_frac;
    if (!en_i) begin
      int_nxt  = div_wr_i ? div_int_i  : shadow_int;
      frac_nxt = div_wr_i ? div_frac_i : shadow_frac;
    end else if (apply) begin
      int_nxt  = shadow_int;
      frac_nxt = shadow_frac;
    end
    clr     = !en_i || (int_nxt == '0);
    restart = resync_i && !clr;
    tick_ev = zero && !clr && !restart;
    half_ev = tick_ev && (os_cnt == CW'(OVS / 2 - 1));
    bit_ev  = tick_ev && (os_cnt == CW'(OVS - 1));
  end

  frac_div #(
    .WORD(WORD),
    .FRAC(FRAC)
  ) u_frac_div (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (clr),
    .restart_i (restart),
    .div_int_i (int_nxt),
    .div_frac_i(frac_nxt),
    .zero_o    (zero)
  );

  // Shadow capture, pending flag and active divisor.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_int  <= '0;
      shadow_frac <= '0;
      act_int     <= '0;
      act_frac    <= '0;
      pending     <= 1'b0;
    end else begin
      if (div_wr_i) begin
        shadow_int  <= div_int_i;
        shadow_frac <= div_frac_i;
      end
      act_int  <= int_nxt;
      act_frac <= frac_nxt;
      pending  <= en_i && (div_wr_i || (pending && !apply));
    end
  end

  // Oversample counter and registered tick/baud outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      os_cnt      <= '0;
      os_tick_o   <= 1'b0;
      half_tick_o <= 1'b0;
      bit_tick_o  <= 1'b0;
      baud_clk_o  <= 1'b0;
      active_o    <= 1'b0;
    end else begin
      active_o <= !clr;
      if (clr || restart) begin
        os_cnt      <= '0;
        os_tick_o   <= 1'b0;
        half_tick_o <= 1'b0;
        bit_tick_o  <= 1'b0;
        baud_clk_o  <= 1'b0;
      end else begin
        os_tick_o   <= tick_ev;
        half_tick_o <= half_ev;
        bit_tick_o  <= bit_ev;
        if (tick_ev) os_cnt <= os_cnt + CW'(1);
        if (half_ev) baud_clk_o <= 1'b1;
        else if (bit_ev) baud_clk_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: per-cycle comparison against a tick-schedule
// model plus directed timing checks.
module tb_baud_tick_gen;

  localparam int WORD = 16;
  localparam int FRAC = 4;
  localparam int OVS  = 16;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            en_i = 1'b0;
  logic [WORD-1:0] div_int_i = '0;
  logic [FRAC-1:0] div_frac_i = '0;
  logic            div_wr_i = 1'b0;
  logic            resync_i = 1'b0;
  logic            os_tick_o, half_tick_o, bit_tick_o, baud_clk_o, active_o;

  always #5 clk = ~clk;

  baud_tick_gen #(
    .WORD(WORD),
    .FRAC(FRAC),
    .OVS (OVS)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .div_int_i  (div_int_i),
    .div_frac_i (div_frac_i),
    .div_wr_i   (div_wr_i),
    .resync_i   (resync_i),
    .os_tick_o  (os_tick_o),
    .half_tick_o(half_tick_o),
    .bit_tick_o (bit_tick_o),
    .baud_clk_o (baud_clk_o),
    .active_o   (active_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int os_q[$];
  int half_q[$];
  int bit_q[$];

  // Model: absolute tick schedule, tick count n since last (re)start.
  int m_sh_i, m_sh_f, m_pend, m_act_i, m_act_f, m_run, m_next, m_acc, m_n;
  int e_os, e_half, e_bit, e_baud, e_act;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_sh_i = 0; m_sh_f = 0; m_pend = 0; m_act_i = 0; m_act_f = 0;
    m_run = 0; m_next = 0; m_acc = 0; m_n = 0;
  endtask

  task automatic model_step();
    int due, app, carry;
    e_os = 0; e_half = 0; e_bit = 0;
    if (!en_i) begin
      if (div_wr_i) begin
        m_sh_i = int'(div_int_i);
        m_sh_f = int'(div_frac_i);
      end
      m_act_i = m_sh_i; m_act_f = m_sh_f;
      m_pend = 0; m_run = 0; m_n = 0; m_acc = 0;
    end else begin
      due = int'(m_run != 0 && cyc == m_next && (m_n % OVS) == OVS - 1);
      app = int'(m_pend != 0 && (resync_i || due != 0 || m_act_i == 0));
      if (app != 0) begin
        m_act_i = m_sh_i; m_act_f = m_sh_f;
      end
      m_pend = int'(div_wr_i || (m_pend != 0 && app == 0));
      if (div_wr_i) begin
        m_sh_i = int'(div_int_i);
        m_sh_f = int'(div_frac_i);
      end
      if (m_act_i == 0) begin
        m_run = 0; m_n = 0; m_acc = 0;
      end else if (resync_i) begin
        m_run = 1; m_next = cyc + m_act_i; m_acc = 0; m_n = 0;
      end else if (m_run == 0) begin
        m_run = 1; m_next = cyc + m_act_i;
      end else if (cyc == m_next) begin
        m_n++;
        m_acc += m_act_f;
        carry = int'(m_acc >= (1 << FRAC));
        if (carry != 0) m_acc -= (1 << FRAC);
        m_next = cyc + m_act_i + carry;
        e_os   = 1;
        e_half = int'((m_n % OVS) == OVS / 2);
        e_bit  = int'((m_n % OVS) == 0);
      end
    end
    e_baud = int'(m_run != 0 && (m_n % OVS) >= OVS / 2);
    e_act  = int'(en_i && m_act_i != 0);
  endtask

  // Compare process: every cycle outside reset.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_i) begin
        model_reset();
      end else begin
        model_step();
        #1;
        chk("os_tick",   int'(os_tick_o),   e_os);
        chk("half_tick", int'(half_tick_o), e_half);
        chk("bit_tick",  int'(bit_tick_o),  e_bit);
        chk("baud_clk",  int'(baud_clk_o),  e_baud);
        chk("active",    int'(active_o),    e_act);
        if (os_tick_o)   os_q.push_back(cyc);
        if (half_tick_o) half_q.push_back(cyc);
        if (bit_tick_o)  bit_q.push_back(cyc);
      end
    end
  end

  // which: 0 = os, 1 = half, 2 = bit. Returns -1 when no such tick.
  function automatic int first_after(input int which, input int t);
    int r = -1;
    if (which == 0) begin
      foreach (os_q[i]) if (r < 0 && os_q[i] > t) r = os_q[i];
    end else if (which == 1) begin
      foreach (half_q[i]) if (r < 0 && half_q[i] > t) r = half_q[i];
    end else begin
      foreach (bit_q[i]) if (r < 0 && bit_q[i] > t) r = bit_q[i];
    end
    return r;
  endfunction

  function automatic int last_bit_le(input int t);
    int r = -1;
    foreach (bit_q[i]) if (bit_q[i] <= t) r = bit_q[i];
    return r;
  endfunction

  function automatic int count_os(input int a, input int b);
    int n = 0;
    foreach (os_q[i]) if (os_q[i] > a && os_q[i] <= b) n++;
    return n;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_div(input int di, input int df, output int w);
    @(negedge clk);
    div_wr_i = 1'b1;
    div_int_i = WORD'(di);
    div_frac_i = FRAC'(df);
    w = cyc + 1;
    @(negedge clk);
    div_wr_i = 1'b0;
  endtask

  task automatic pulse_rs(output int r);
    @(negedge clk);
    resync_i = 1'b1;
    r = cyc + 1;
    @(negedge clk);
    resync_i = 1'b0;
  endtask

  initial begin
    int w, s, r, r0, b0, b1, b2, b3, e, rel;

    #3;
    chk("rst_os0",   int'(os_tick_o),  0);
    chk("rst_baud0", int'(baud_clk_o), 0);
    @(negedge clk);
    rst_i = 1'b0;
    en_i  = 1'b1;
    tick(5);
    chk("idle_after_rst", int'(active_o), 0);
    chk("idle_no_ticks", os_q.size(), 0);

    // div 4.0 from idle
    write_div(4, 0, w);
    s = w + 1;
    tick(200);
    chk("d4_first_os", first_after(0, s), s + 4);
    chk("d4_os_gap",   first_after(0, s + 4), s + 8);
    chk("d4_half",     first_after(1, s), s + 32);
    chk("d4_bit0",     first_after(2, s), s + 64);
    chk("d4_bit_gap",  first_after(2, s + 64), s + 128);

    // div 8.0 written mid-bit
    write_div(8, 0, w);
    b0 = last_bit_le(w);
    tick(300);
    b1 = first_after(2, w);
    b2 = first_after(2, b1);
    chk("d8_cur_bit",  b1 - b0, 64);
    chk("d8_next_bit", b2 - b1, 128);

    // resync at os count 5 (div 4.0 applied by first resync)
    write_div(4, 0, w);
    pulse_rs(r0);
    tick(21);
    pulse_rs(r);
    tick(80);
    chk("rs_os_before", count_os(r0, r), 5);
    chk("rs_next_os",   first_after(0, r - 1), r + 4);
    chk("rs_bit",       first_after(2, r), r + 64);

    // div 1.0: tick every cycle
    write_div(1, 0, w);
    pulse_rs(r);
    tick(20);
    chk("d1_every_cycle", count_os(r, r + 16), 16);

    // div 3.5
    write_div(3, 8, w);
    pulse_rs(r);
    tick(250);
    chk("d35_first_os", first_after(0, r), r + 3);
    b1 = first_after(2, r);
    b2 = first_after(2, b1);
    b3 = first_after(2, b2);
    chk("d35_bit_gap", b3 - b2, 56);
    chk("d35_os_per_bit", count_os(b2, b3), 16);

    // en low mid-bit for 3 edges
    tick(20);
    en_i = 1'b0;
    e = cyc + 1;
    @(negedge clk);
    chk("en0_outputs", int'({os_tick_o, half_tick_o, bit_tick_o, baud_clk_o, active_o}), 0);
    @(negedge clk);
    @(negedge clk);
    en_i = 1'b1;
    s = cyc + 1;
    tick(30);
    chk("en1_first_os", first_after(0, e), s + 3);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      en_i     = ($urandom_range(0, 49) != 0);
      div_wr_i = ($urandom_range(0, 39) == 0);
      resync_i = ($urandom_range(0, 59) == 0);
      div_int_i  = ($urandom_range(0, 9) == 0) ? '0 : WORD'($urandom_range(1, 5));
      div_frac_i = FRAC'($urandom);
    end
    @(negedge clk);
    en_i = 1'b1; div_wr_i = 1'b0; resync_i = 1'b0;

    // reset mid-bit
    write_div(4, 0, w);
    pulse_rs(r);
    tick(40);
    #2 rst_i = 1'b1;
    #1;
    chk("rstmid_os",     int'(os_tick_o),  0);
    chk("rstmid_baud",   int'(baud_clk_o), 0);
    chk("rstmid_active", int'(active_o),   0);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    rel = cyc;
    tick(100);
    chk("rst_silent", count_os(rel, cyc), 0);
    chk("rst_inactive", int'(active_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
